// File: rtl/addsub_pkg.sv
// Shared encodings for the multi-cycle add/subtract sequencer.
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_slice.sv
// SLICE-bit combinational ripple-carry adder built from full-adder cells.
module addsub_slice #(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  logic [SLICE:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SLICE];

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Add/subtract sequencer: one shared ripple slice walks the operands over
// WIDTH/SLICE cycles, with valid/ready handshakes on both sides.
module addsub_seq_ctrl
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t             state, state_n;
  logic [WIDTH-1:0]   xr, xr_n, yr, yr_n, sum_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic               carry, carry_n;
  logic               cout_n, ovf_n, zero_n, out_valid_n, in_ready_n, busy_n;
  logic [SLICE-1:0]   slice_a, slice_b, slice_s;
  logic               slice_co;
  int unsigned        base;
  logic               last;

  // Operand slice selected by the current index feeds the shared adder.
  assign base    = 32'(idx) * SLICE;
  assign slice_a = xr[base +: SLICE];
  assign slice_b = yr[base +: SLICE];
  assign last    = (idx == IDX_W'(NSLICE - 1));

  addsub_slice #(.SLICE(SLICE)) u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry),
    .s   (slice_s),
    .cout(slice_co)
  );

  always_comb begin
    state_n     = state;
    xr_n        = xr;
    yr_n        = yr;
    carry_n     = carry;
    idx_n       = idx;
    sum_n       = sum;
    cout_n      = cout;
    ovf_n       = ovf;
    zero_n      = zero;
    out_valid_n = out_valid;
    case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          xr_n    = x;
          yr_n    = y ^ {WIDTH{op_sub == OP_SUB}};
          carry_n = (op_sub == OP_SUB);
          idx_n   = '0;
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_n[base +: SLICE] = slice_s;
        carry_n              = slice_co;
        idx_n                = idx + IDX_W'(1);
        if (last) begin
          state_n     = ST_DONE;
          cout_n      = slice_co;
          ovf_n       = (xr[WIDTH-1] == yr[WIDTH-1]) && (sum_n[WIDTH-1] != xr[WIDTH-1]);
          zero_n      = (sum_n == '0);
          out_valid_n = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_valid && out_ready) begin
          out_valid_n = 1'b0;
          state_n     = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // Handshake status tracks the state being entered so it is a clean flop.
    in_ready_n = (state_n == ST_IDLE);
    busy_n     = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      xr        <= '0;
      yr        <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      xr        <= xr_n;
      yr        <= yr_n;
      carry     <= carry_n;
      idx       <= idx_n;
      sum       <= sum_n;
      cout      <= cout_n;
      ovf       <= ovf_n;
      zero      <= zero_n;
      out_valid <= out_valid_n;
      in_ready  <= in_ready_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed and random checks of the add/subtract sequencer against a
// scoreboard of expected results.
module tb_addsub_seq_ctrl;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned SLICE  = 8;
  localparam int unsigned NSLICE = WIDTH / SLICE;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  res_t sb[$];

  addsub_seq_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_sub   (op_sub),
    .x        (x),
    .y        (y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: signed range test for overflow, unsigned compare/carry for cout.
  function automatic res_t model(input logic sub, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    res_t          r;
    longint        full;
    logic [WIDTH:0] wide;
    if (sub) begin
      full   = longint'($signed(a)) - longint'($signed(b));
      r.sum  = a - b;
      r.cout = (a >= b);
    end else begin
      full   = longint'($signed(a)) + longint'($signed(b));
      wide   = {1'b0, a} + {1'b0, b};
      r.sum  = wide[WIDTH-1:0];
      r.cout = wide[WIDTH];
    end
    r.ovf  = (full > 64'sd2147483647) || (full < -64'sd2147483648);
    r.zero = (r.sum == '0);
    return r;
  endfunction

  task automatic send(input logic sub, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input res_t exp);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", 64'(in_ready), 64'(1));
    op_sub   = sub;
    x        = a;
    y        = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    sb.push_back(exp);
  endtask

  task automatic recv(input int hold, input bit chk_lat);
    int   n = 0;
    res_t got;
    res_t exp;
    out_ready = 1'b0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("out_valid_seen", 64'(out_valid), 64'(1));
    if (chk_lat) check("latency", 64'(cyc - acc_cyc), 64'(NSLICE));
    got = '{sum, cout, ovf, zero};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_in_ready", 64'(in_ready), 64'(0));
      check("hold_busy", 64'(busy), 64'(1));
      check("hold_stable", 64'({sum, cout, ovf, zero}), 64'(got));
    end
    in_valid = 1'b0;
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 64'(0), 64'(1));
    end else begin
      exp = sb.pop_front();
      check("sum", 64'(sum), 64'(exp.sum));
      check("cout", 64'(cout), 64'(exp.cout));
      check("ovf", 64'(ovf), 64'(exp.ovf));
      check("zero", 64'(zero), 64'(exp.zero));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("handoff_valid", 64'(out_valid), 64'(0));
    check("handoff_in_ready", 64'(in_ready), 64'(1));
  endtask

  initial begin
    logic             rs;
    logic [WIDTH-1:0] ra, rb;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_sub    = 1'b0;
    x         = '0;
    y         = '0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_flags", 64'({sum, cout, ovf, zero}), 64'(0));

    send(1'b0, 32'd10, 32'd15, '{32'd25, 1'b0, 1'b0, 1'b0});
    recv(0, 1'b1);
    send(1'b1, 32'd10, 32'd15, '{32'hFFFF_FFFB, 1'b0, 1'b0, 1'b0});
    recv(0, 1'b1);
    send(1'b1, 32'd15, 32'd10, '{32'd5, 1'b1, 1'b0, 1'b0});
    recv(0, 1'b1);
    send(1'b0, 32'h7FFF_FFFF, 32'd1, '{32'h8000_0000, 1'b0, 1'b1, 1'b0});
    recv(0, 1'b1);
    send(1'b0, 32'h00FF_FFFF, 32'd1, '{32'h0100_0000, 1'b0, 1'b0, 1'b0});
    recv(0, 1'b1);

    // Backpressure with a stray request held during RUN and DONE.
    send(1'b0, 32'h1234_5678, 32'h1111_1111, '{32'h2345_6789, 1'b0, 1'b0, 1'b0});
    op_sub   = 1'b1;
    x        = 32'hAAAA_AAAA;
    y        = 32'h5555_5555;
    in_valid = 1'b1;
    check("run_in_ready", 64'(in_ready), 64'(0));
    check("run_busy", 64'(busy), 64'(1));
    recv(3, 1'b1);
    @(posedge clk); #1;
    check("post_idle_busy", 64'(busy), 64'(0));
    check("post_idle_ready", 64'(in_ready), 64'(1));

    send(1'b0, 32'hFFFF_FFFF, 32'd1, '{32'd0, 1'b1, 1'b0, 1'b1});
    recv(1, 1'b1);

    // Reset lands while the third slice is being processed.
    send(1'b0, 32'h5555_5555, 32'h6666_6666, '{32'hBBBB_BBBB, 1'b0, 1'b1, 1'b0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_sum", 64'(sum), 64'(0));
    check("midrst_flags", 64'({cout, ovf, zero}), 64'(0));
    send(1'b0, 32'd3, 32'd4, '{32'd7, 1'b0, 1'b0, 1'b0});
    recv(0, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: rb = ~ra;
        2: ra = 32'h8000_0000;
        3: rb = 32'h7FFF_FFFF;
        default: ;
      endcase
      send(rs, ra, rb, model(rs, ra, rb));
      recv($urandom_range(0, 2), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
